complex_mult_requester: RTL

//   Requester for complex_nr_mult_* style multipliers. Buffers operand sets from upstream,

---
 rtl/complex_mult_requester.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/complex_mult_requester.sv
// Requester for a complex multiplier: operand FIFO in front of a single-outstanding op/res
// handshake, registered output stage, wrapping transaction counter and sticky response timeout.
module complex_mult_requester #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    sw_rst,
   input  logic                    in_val,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_op_1_re,
   input  logic [DATA_WIDTH-1:0]   in_op_1_im,
   input  logic [DATA_WIDTH-1:0]   in_op_2_re,
   input  logic [DATA_WIDTH-1:0]   in_op_2_im,
   output logic                    op_val,
   input  logic                    op_ready,
   output logic [DATA_WIDTH-1:0]   op_1_re,
   output logic [DATA_WIDTH-1:0]   op_1_im,
   output logic [DATA_WIDTH-1:0]   op_2_re,
   output logic [DATA_WIDTH-1:0]   op_2_im,
   input  logic                    res_val,
   output logic                    res_ready,
   input  logic [2*DATA_WIDTH-1:0] result_re,
   input  logic [2*DATA_WIDTH-1:0] result_im,
   output logic                    out_val,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_re,
   output logic [2*DATA_WIDTH-1:0] out_im,
   output logic                    busy,
   output logic [15:0]             txn_count,
   output logic                    timeout_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] op_1_re;
      logic [DATA_WIDTH-1:0] op_1_im;
      logic [DATA_WIDTH-1:0] op_2_re;
      logic [DATA_WIDTH-1:0] op_2_im;
   } opset_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

   opset_t                  mem_q [FIFO_DEPTH];
   opset_t                  head;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]             count_q, count_d;
   logic [15:0]             txn_count_q, txn_count_d;
   state_t                  state_q;
   logic [TW-1:0]           timer_q;
   logic                    out_val_q, timeout_err_q;
   logic [2*DATA_WIDTH-1:0] out_re_q, out_im_q;
   logic                    push, pop, capture;

   // in_ready looks only at the registered count, so a full FIFO refuses a push even while popping.
   assign in_ready  = (count_q != DEPTH_C);
   assign push      = in_val & in_ready & ~sw_rst;
   assign op_val    = (state_q == ISSUE);
   assign pop       = op_val & op_ready;
   assign res_ready = (state_q == WAIT_RES) & (~out_val_q | out_ready);
   assign capture   = res_val & res_ready;
   assign head      = mem_q[rd_ptr_q];

   assign op_1_re     = op_val ? head.op_1_re : '0;
   assign op_1_im     = op_val ? head.op_1_im : '0;
   assign op_2_re     = op_val ? head.op_2_re : '0;
   assign op_2_im     = op_val ? head.op_2_im : '0;
   assign out_val     = out_val_q;
   assign out_re      = out_re_q;
   assign out_im      = out_im_q;
   assign txn_count   = txn_count_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q != IDLE) | (count_q != '0);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      txn_count_d = txn_count_q + 16'(capture);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         txn_count_q <= '0;
      end else if (sw_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         txn_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         txn_count_q <= txn_count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{in_op_1_re, in_op_1_im, in_op_2_re, in_op_2_im};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         out_val_q     <= 1'b0;
         out_re_q      <= '0;
         out_im_q      <= '0;
         timeout_err_q <= 1'b0;
      end else if (sw_rst) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         out_val_q     <= 1'b0;
         out_re_q      <= '0;
         out_im_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         // A capture in the same cycle as a downstream take keeps out_val high.
         if (capture) begin
            out_val_q <= 1'b1;
            out_re_q  <= result_re;
            out_im_q  <= result_im;
         end else if (out_ready) begin
            out_val_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (count_q != '0) state_q <= ISSUE;
            end
            ISSUE: begin
               if (op_ready) begin
                  state_q <= WAIT_RES;
                  timer_q <= '0;
               end
            end
            WAIT_RES: begin
               if (capture) begin
                  state_q <= (count_q != '0) ? ISSUE : IDLE;
               end else if (timer_q == TLAST_C) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
